array_feeder_b: RTL
===================

// Module: array_feeder_B
// PURPOSE
//  Read-side sequencer for the matrix-B tile memory. On start, drives the four read ports
//  (r_en, read_addr_0..3) to fetch one 4x4 column-major tile. Returns a column-skewed
//  stream (column j delayed j cycles) onto the top edge of the 4x4 systolic array.
//  Sits between the B memory and the array; the top-level controller drives start/hold.
// PARAMETERS
//  DATA_W   16  element width, equal to the memory word width
//  ADDR_W   7   memory address width (128 words)
//  DIM      4   array dimension; fixed at 4 to match the four memory read ports
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous, active-high reset
//  start        in   1       one-cycle request to stream one tile; sampled only in IDLE
//  base_addr    in   ADDR_W  tile base address; latched when start is accepted
//  hold         in   1       array stall; freezes the whole feeder
//  busy         out  1       high from the cycle after start is accepted until done
//  done         out  1       one-cycle pulse when the last column-3 beat has left
//  r_en         out  1       memory read enable
//  read_addr_j  out  ADDR_W  j=0..3, address for memory read port j
//  read_data_j  in   DATA_W  j=0..3, memory data; 1-cycle registered latency, held while r_en=0
//  b_out_j      out  DATA_W  j=0..3, element to array column j; 0 when not valid
//  b_valid_j    out  1       j=0..3, b_out_j carries a real element
// BEHAVIOUR
//  Reset: all outputs are 0 and the FSM returns to IDLE. Reset mid-tile aborts with no done pulse.
//  FSM: IDLE -> READ (4 beats, k=0..3) -> DRAIN (4 beats: 1 memory latency + 3 skew) -> IDLE.
//   done pulses on the DRAIN->IDLE transition. busy=1 in READ and DRAIN.
//  Addressing in READ beat k: r_en=1 and read_addr_j = base+DIM*j+k, mod 2^ADDR_W (wraps).
//   Outside READ, r_en=0 and the addresses hold their last value.
//  rd_vld register: set to 1 at the end of each non-held READ beat. It qualifies read_data_0..3.
//  Skew: column j passes read_data_j through a j-stage delay line, with the valid bit carried
//   alongside. b_out_0/b_valid_0 = read_data_0/rd_vld, with 0 forced when not valid.
//  Timing with hold=0 (start sampled in cycle 0):
//   - READ occupies cycles 1-4.
//   - b_valid_j is high in cycles 2+j .. 5+j.
//   - Beat k of column j equals mem[base+4j+k].
//   - done pulses in cycle 9, and busy falls in cycle 9.
//  hold=1:
//   - r_en is forced to 0.
//   - FSM, beat counter, rd_vld and all delay lines are frozen.
//   - b_out/b_valid hold their values.
//   - Read data already in flight stays valid because the memory holds read_data while r_en=0.
//   - hold in IDLE also blocks start acceptance.
//  start while busy: ignored. start in the done cycle: accepted, and READ begins the next cycle.
//  start and rst in the same cycle: rst wins.
// STRUCTURE
//  Shared package sa_pkg:
//   - constants DIM=4, DATA_W=16, ADDR_W=7, TILE_WORDS=16
//   - FSM state encoding (IDLE, READ, DRAIN)
//  One sub-module: skew_delay_line. It is a parameterized (DEPTH, WIDTH) shift register with an
//   enable and a sync reset. It is instantiated for columns 1..3 with DEPTH=j, and carries
//   {valid,data}.
//  Top level holds the FSM, the 2-bit beat/drain counter, the base latch and the address adders.
// TESTING
//  Memory model: 1-cycle registered read. Content mem[a]=a.
//  1. rst, then start with base=0, hold=0:
//     - r_en high in cycles 1-4
//     - column j outputs 4j..4j+3 in cycles 2+j..5+j
//     - done in cycle 9
//  2. base=120: column 2 reads addresses 0,1,2,3 (wrap), so b_out_2 = 0,1,2,3.
//  3. hold pulsed for 2 cycles during READ beat 2 and again during DRAIN:
//     - the sequence is identical to test 1, stretched by 2 cycles per hold
//     - done in cycle 13
//  4. start re-asserted during busy: ignored, with exactly one done.
//     start in the done cycle: a second tile begins the next cycle with no gap.
//  5. rst asserted in cycle 6 of a tile:
//     - all outputs 0 in cycle 7
//     - no done pulse
//     - a fresh start then runs the normal test-1 timing
//  6. Idle check: with no start, r_en, b_valid_j, busy and done stay 0 for 50 cycles.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared constants for the systolic-array feeders.
// Holds array geometry, word sizes and the feeder FSM encoding.
package sa_pkg;

    localparam int DIM        = 4;
    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 7;
    localparam int TILE_WORDS = DIM * DIM;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/array_feeder_b_skew_delay_line.sv
// Enabled shift register used to skew one array column.
// Stage 0 takes the input, stage DEPTH-1 drives the output.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    // Shift one position when enabled, otherwise hold every stage.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (en) begin
            stage_d[0] = d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // Stage registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/array_feeder_b.sv
// Matrix-B read sequencer: fetches a 4x4 column-major tile and
// presents it column-skewed to the top edge of the systolic array.
module array_feeder_b
    import sa_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic              r_en,
    output logic [ADDR_W-1:0] read_addr_0,
    output logic [ADDR_W-1:0] read_addr_1,
    output logic [ADDR_W-1:0] read_addr_2,
    output logic [ADDR_W-1:0] read_addr_3,
    input  logic [DATA_W-1:0] read_data_0,
    input  logic [DATA_W-1:0] read_data_1,
    input  logic [DATA_W-1:0] read_data_2,
    input  logic [DATA_W-1:0] read_data_3,
    output logic [DATA_W-1:0] b_out_0,
    output logic [DATA_W-1:0] b_out_1,
    output logic [DATA_W-1:0] b_out_2,
    output logic [DATA_W-1:0] b_out_3,
    output logic              b_valid_0,
    output logic              b_valid_1,
    output logic              b_valid_2,
    output logic              b_valid_3
);

    localparam int         BEATS = TILE_WORDS / DIM;
    localparam logic [1:0] LAST  = 2'(BEATS - 1);

    logic [1:0]        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              rd_vld_q, rd_vld_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_q [DIM];
    logic [ADDR_W-1:0] addr_d [DIM];
    logic [DATA_W-1:0] rdata [DIM];
    logic [DATA_W:0]   lane [DIM];
    logic              in_read;

    assign in_read  = (state_q == ST_READ);
    assign rdata[0] = read_data_0;
    assign rdata[1] = read_data_1;
    assign rdata[2] = read_data_2;
    assign rdata[3] = read_data_3;

    // Sequencing: READ and DRAIN each last four beats; hold freezes all.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        base_d   = base_q;
        rd_vld_d = rd_vld_q;
        done_d   = 1'b0;
        if (!hold) begin
            rd_vld_d = in_read;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_READ;
                        cnt_d   = 2'd0;
                        base_d  = base_addr;
                    end
                end
                ST_READ: begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == LAST) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == LAST) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Column j reads base+DIM*j+k; addresses park outside READ.
    always_comb begin
        for (int j = 0; j < DIM; j++) begin
            addr_d[j] = addr_q[j];
            if (in_read) begin
                addr_d[j] = base_q + ADDR_W'(DIM * j)
                          + ADDR_W'(cnt_q);
            end
        end
    end

    // State, counter, base latch and parked addresses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 2'd0;
            base_q   <= '0;
            rd_vld_q <= 1'b0;
            done_q   <= 1'b0;
            for (int j = 0; j < DIM; j++) begin
                addr_q[j] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            rd_vld_q <= rd_vld_d;
            done_q   <= done_d;
            for (int j = 0; j < DIM; j++) begin
                addr_q[j] <= addr_d[j];
            end
        end
    end

    assign lane[0] = {rd_vld_q, rdata[0]};

    for (genvar j = 1; j < DIM; j++) begin : g_skew
        skew_delay_line #(
            .DEPTH (j),
            .WIDTH (DATA_W + 1)
        ) u_dly (
            .clk (clk),
            .rst (rst),
            .en  (!hold),
            .d   ({rd_vld_q, rdata[j]}),
            .q   (lane[j])
        );
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign r_en        = in_read && !hold;
    assign read_addr_0 = addr_d[0];
    assign read_addr_1 = addr_d[1];
    assign read_addr_2 = addr_d[2];
    assign read_addr_3 = addr_d[3];
    assign b_valid_0   = lane[0][DATA_W];
    assign b_valid_1   = lane[1][DATA_W];
    assign b_valid_2   = lane[2][DATA_W];
    assign b_valid_3   = lane[3][DATA_W];
    assign b_out_0     = lane[0][DATA_W] ? lane[0][DATA_W-1:0] : '0;
    assign b_out_1     = lane[1][DATA_W] ? lane[1][DATA_W-1:0] : '0;
    assign b_out_2     = lane[2][DATA_W] ? lane[2][DATA_W-1:0] : '0;
    assign b_out_3     = lane[3][DATA_W] ? lane[3][DATA_W-1:0] : '0;

endmodule
